hh_neuron_scheduler: RTL
========================

Name: hh_neuron_scheduler

Overview:
- Time-multiplexes one shared Hodgkin-Huxley update datapath across NUM_NEURONS neurons.
- Holds per-neuron state (V, n, m, h) and the input current, all Q9.5 signed, 14 bit.
- On each timestep tick, sweeps neurons 0..NUM_NEURONS-1 through the datapath over a valid/ready request/response handshake, writes the results back and reports threshold-crossing spikes.

Parameters:
NUM_NEURONS, 4, neurons in the state file (2..16)
W, 14, state/current word width, Q9.5 signed
V_INIT, 14'h37E0, reset membrane voltage (-65.0)
N_INIT, 14'd10, reset n gate (0.3125)
M_INIT, 14'd2, reset m gate (0.0625)
H_INIT, 14'd19, reset h gate (0.59375)
SPIKE_THRESH, 14'd0, signed spike threshold (0.0)
TIMEOUT, 64, response watchdog cycles (used only with HH_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
tick  in  1  start one timestep sweep (single-cycle pulse)
cfg_we  in  1  write current register
cfg_idx  in  4  neuron index for cfg_we (values >= NUM_NEURONS are ignored)
cfg_current  in  W  current value to write
dp_req_valid  out  1  request to datapath
dp_req_ready  in  1  datapath accepts request
dp_v, dp_n, dp_m, dp_h, dp_i  out  W each  state and current of the selected neuron
dp_rsp_valid  in  1  result valid (single-cycle)
dp_v_new, dp_n_new, dp_m_new, dp_h_new  in  W each  updated state
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse at end of sweep
spike_out  out  NUM_NEURONS  spike flags of the last completed sweep
overrun  out  1  sticky: tick received while busy
dp_err  out  1  sticky: response watchdog expired

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - every V/n/m/h = V_INIT/N_INIT/M_INIT/H_INIT; all currents = 0.
  - FSM = IDLE; idx = 0.
  - busy, dp_req_valid, sweep_done, spike_out, overrun, dp_err = 0.
  - Reset mid-sweep aborts the sweep; no partial writeback survives.
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE: tick=1 -> ISSUE with idx=0, busy=1 from the next cycle.
- ISSUE: dp_req_valid=1. dp_* driven from registers[idx] and stay stable while valid and not ready. Request fires when valid&&ready -> WAIT.
- WAIT:
  - dp_req_valid=0; scheduler is always ready for a response.
  - On dp_rsp_valid, write dp_*_new into registers[idx] the same edge.
  - Spike bit for idx = (old V < SPIKE_THRESH) && (dp_v_new >= SPIKE_THRESH), signed compare, held in a shadow vector.
  - Then -> NEXT.
  - dp_rsp_valid outside WAIT is ignored.
- NEXT: idx == NUM_NEURONS-1 -> DONE; otherwise idx+1 -> ISSUE.
- DONE:
  - sweep_done=1 for exactly one cycle; spike_out <= shadow vector; shadow cleared.
  - idx=0; -> IDLE; busy=0 in the cycle after DONE.
  - spike_out holds until the next DONE.
- Latency (ready and response both asserted the first cycle they can be):
  - 3 cycles per neuron (ISSUE, WAIT, NEXT).
  - Full sweep = 3*NUM_NEURONS+1 cycles from the first busy cycle to sweep_done.
- tick while busy (including the DONE cycle): ignored, overrun set sticky. Only reset clears overrun.
- cfg_we:
  - Accepted in any state; takes effect at the next edge.
  - A write to the neuron currently in ISSUE must not change dp_i until the request fires. The write is buffered and applied at the handshake edge.
  - The current value is used by the next sweep.
- No arithmetic in the block; values pass through unmodified. Wrap and saturation are the datapath's responsibility.

Optional Feature:
HH_SCHED_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT. If it reaches TIMEOUT cycles with no dp_rsp_valid, the neuron keeps its old state, its spike bit = 0, dp_err is set sticky, and the FSM -> NEXT.
  - Counter clears on entering WAIT.
- Not defined: WAIT lasts indefinitely; dp_err is tied to 0; no counter logic.

Test Plan:
1. Reset, then tick; datapath always ready and responds after 1 cycle with V+1.0 (14'h0020) -> each V = 14'h3800 (-64.0); sweep_done exactly 13 cycles after the first busy cycle (NUM_NEURONS=4); spike_out=4'b0000.
2. Preload neuron 2 with V = -0.5 (14'h3FF0) over two sweeps; datapath returns 14'h0040 (+2.0) for neuron 2 -> spike_out=4'b0100. Next sweep returns 14'h0060 -> spike_out=4'b0000, since no new crossing.
3. dp_req_ready held low for 5 cycles with neuron 1 selected -> dp_req_valid stays 1; dp_v/dp_n/dp_m/dp_h/dp_i stable; cfg_we to idx 1 with 14'h0140 (10.0) in that window does not change dp_i until the handshake; next sweep dp_i=14'h0140.
4. Pulse tick at busy cycle 4 -> sweep unaffected; overrun=1 and remains 1 through the next idle tick.
5. Assert rst_n=0 while in WAIT for neuron 3 -> next cycle all state equals the INIT values; busy=0; spike_out=0; overrun=0.
6. With HH_SCHED_TIMEOUT_EN and TIMEOUT=64: no response for neuron 0 -> after 64 WAIT cycles dp_err=1, neuron 0 unchanged, sweep completes for neurons 1-3. Without the macro: busy stays 1 indefinitely; dp_err=0.

Source files
------------

// File: rtl/hh_neuron_scheduler.sv
// hh_neuron_scheduler
//
// Purpose:
//   Shares one external Hodgkin-Huxley update datapath between NUM_NEURONS
//   neurons. A per-neuron state file (V, n, m, h) and input current register
//   are held here in Q9.5 signed format. Each tick starts a sweep that walks
//   the neurons in index order, sends each one to the datapath over a
//   valid/ready request, writes the returned state back and records any
//   upward crossing of SPIKE_THRESH. Values pass through unmodified.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   tick              single-cycle pulse that starts a sweep
//   cfg_we/cfg_idx/cfg_current
//                     current-register write; out-of-range indices ignored
//   dp_req_valid/dp_req_ready, dp_v/dp_n/dp_m/dp_h/dp_i
//                     request channel carrying the selected neuron
//   dp_rsp_valid, dp_v_new/dp_n_new/dp_m_new/dp_h_new
//                     single-cycle response with the updated state
//   busy              sweep in progress
//   sweep_done        one-cycle pulse in the final cycle of a sweep
//   spike_out         spike flags of the last completed sweep
//   overrun           sticky: tick seen while busy
//   dp_err            sticky: response watchdog expired
//
// Build option:
//   HH_SCHED_TIMEOUT_EN  enables a TIMEOUT-cycle response watchdog in WAIT.
//                        Without it WAIT waits forever and dp_err is 0.

module hh_neuron_scheduler #(
  parameter int             NUM_NEURONS  = 4,
  parameter int             W            = 14,
  parameter logic [W-1:0]   V_INIT       = 14'h37E0,
  parameter logic [W-1:0]   N_INIT       = 14'd10,
  parameter logic [W-1:0]   M_INIT       = 14'd2,
  parameter logic [W-1:0]   H_INIT       = 14'd19,
  parameter logic [W-1:0]   SPIKE_THRESH = 14'd0,
  parameter int             TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_idx,
  input  logic [W-1:0]           cfg_current,
  output logic                   dp_req_valid,
  input  logic                   dp_req_ready,
  output logic [W-1:0]           dp_v,
  output logic [W-1:0]           dp_n,
  output logic [W-1:0]           dp_m,
  output logic [W-1:0]           dp_h,
  output logic [W-1:0]           dp_i,
  input  logic                   dp_rsp_valid,
  input  logic [W-1:0]           dp_v_new,
  input  logic [W-1:0]           dp_n_new,
  input  logic [W-1:0]           dp_m_new,
  input  logic [W-1:0]           dp_h_new,
  output logic                   busy,
  output logic                   sweep_done,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   overrun,
  output logic                   dp_err
);

  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0] v_mem [NUM_NEURONS];
  logic [W-1:0] n_mem [NUM_NEURONS];
  logic [W-1:0] m_mem [NUM_NEURONS];
  logic [W-1:0] h_mem [NUM_NEURONS];
  logic [W-1:0] i_mem [NUM_NEURONS];

  logic [IW-1:0]          idx;
  logic [NUM_NEURONS-1:0] spike_shadow;
  logic                   pend_valid;
  logic [W-1:0]           pend_current;

  logic          cfg_hit;
  logic [IW-1:0] cfg_sel;
  logic          req_fire;
  logic          rsp_take;
  logic          crossed;
  logic          timeout_hit;

  assign cfg_hit  = cfg_we && ({1'b0, cfg_idx} < 5'(NUM_NEURONS));
  assign cfg_sel  = cfg_idx[IW-1:0];
  assign req_fire = (state == ISSUE) && dp_req_ready;
  assign rsp_take = (state == WAIT) && dp_rsp_valid;

  // A spike is an upward crossing: old V strictly below, new V at or above.
  assign crossed = ($signed(v_mem[idx]) <  $signed(SPIKE_THRESH)) &&
                   ($signed(dp_v_new)   >= $signed(SPIKE_THRESH));

  assign dp_v = v_mem[idx];
  assign dp_n = n_mem[idx];
  assign dp_m = m_mem[idx];
  assign dp_h = h_mem[idx];
  assign dp_i = i_mem[idx];

`ifdef HH_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] wait_cnt;
  logic          dp_err_q;

  // The counter sits at zero outside WAIT, so it starts from zero on every
  // entry; the last WAIT cycle without a response abandons the neuron.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      dp_err_q <= 1'b0;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else               wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) dp_err_q <= 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT) && !dp_rsp_valid &&
                       (wait_cnt == TW'(TIMEOUT - 1));
  assign dp_err      = dp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign dp_err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next   = state;
    dp_req_valid = 1'b0;
    busy         = 1'b1;
    sweep_done   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick) state_next = ISSUE;
      end
      ISSUE: begin
        dp_req_valid = 1'b1;
        if (dp_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (dp_rsp_valid || timeout_hit) state_next = NEXT;
      end
      NEXT: begin
        state_next = (idx == LAST_IDX) ? DONE : ISSUE;
      end
      DONE: begin
        sweep_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State file, index, spike capture and sticky flags. A current write aimed
  // at the neuron currently offered in ISSUE is parked in pend_* so dp_i
  // stays stable, then committed on the handshake edge; a direct write on
  // that same edge is newer and overrides the parked value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k] <= V_INIT;
        n_mem[k] <= N_INIT;
        m_mem[k] <= M_INIT;
        h_mem[k] <= H_INIT;
        i_mem[k] <= '0;
      end
      idx          <= '0;
      spike_shadow <= '0;
      spike_out    <= '0;
      overrun      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_current <= '0;
    end else begin
      if (req_fire && pend_valid) begin
        i_mem[idx] <= pend_current;
        pend_valid <= 1'b0;
      end
      if (cfg_hit) begin
        if ((state == ISSUE) && !dp_req_ready && (cfg_sel == idx)) begin
          pend_valid   <= 1'b1;
          pend_current <= cfg_current;
        end else begin
          i_mem[cfg_sel] <= cfg_current;
        end
      end
      if (rsp_take) begin
        v_mem[idx]        <= dp_v_new;
        n_mem[idx]        <= dp_n_new;
        m_mem[idx]        <= dp_m_new;
        h_mem[idx]        <= dp_h_new;
        spike_shadow[idx] <= crossed;
      end
      if (tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) idx <= '0;
        NEXT: if (idx != LAST_IDX) idx <= idx + 1'b1;
        DONE: begin
          spike_out    <= spike_shadow;
          spike_shadow <= '0;
          idx          <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
